// File: rtl/serial_add_sub4.sv
// Bit-serial WIDTH-bit adder/subtractor built from one full-adder slice (two half adders + OR).
// Latency: start accepted at edge k, result registered at edge k+WIDTH, done high for the next cycle.
// Backpressure: none; start is only honoured in IDLE/DONE and is dropped (not queued) while busy.
module serial_add_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shift registers; LSB feeds the adder slice each step.
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  // Low WIDTH-1 result bits; the final sum bit is joined on completion.
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full-adder slice as two half-adder cells and an OR gate.
  logic ha1_s;
  logic ha1_c;
  logic ha2_s;
  logic ha2_c;
  logic fa_cout;

  assign ha1_s   = opa[0] ^ opb[0];
  assign ha1_c   = opa[0] & opb[0];
  assign ha2_s   = ha1_s ^ carry;
  assign ha2_c   = ha1_s & carry;
  assign fa_cout = ha1_c | ha2_c;

  logic last_step;
  logic accept;

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign accept    = start && ((state == IDLE) || (state == DONE));

  // Next-state and status decode; busy and done come straight from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, one serial bit step per cycle, and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      opa   <= {1'b0, opa[WIDTH-1:1]};
      opb   <= {1'b0, opb[WIDTH-1:1]};
      res   <= {ha2_s, res[WIDTH-2:1]};
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        // On the MSB step the carry register still holds the carry into the MSB,
        // so overflow is that value XOR the carry out of the MSB.
        s <= {ha2_s, res};
        c <= fa_cout;
        v <= carry ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub4.sv
module tb_serial_add_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c;
  logic         v;

  int npass = 0;
  int ntotal = 0;

  // Expected registered outputs, maintained by the bench.
  logic [W-1:0] exp_s;
  logic         exp_c;
  logic         exp_v;

  serial_add_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c),
    .v     (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                       output logic [W-1:0] ms, output logic mc, output logic mv);
    int full;
    if (tsub) full = int'(ta) + ((~int'(tb)) & ((1 << W) - 1)) + 1;
    else      full = int'(ta) + int'(tb);
    ms = full[W-1:0];
    mc = full[W];
    if (tsub) mv = (ta[W-1] != tb[W-1]) && (ms[W-1] != ta[W-1]);
    else      mv = (ta[W-1] == tb[W-1]) && (ms[W-1] != ta[W-1]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Called just after a negedge with the DUT in IDLE or DONE. Returns just after
  // the negedge following the done edge (DUT in DONE).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub);
    logic [W-1:0] ms;
    logic mc, mv;
    model(ta, tb, tsub, ms, mc, mv);
    start = 1'b1; a = ta; b = tb; sub = tsub;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check("busy during shift", 32'(busy), 32'd1);
      check("done during shift", 32'(done), 32'd0);
      check("s held during shift", 32'(s), 32'(exp_s));
      @(negedge clk);
    end
    exp_s = ms; exp_c = mc; exp_v = mv;
    check("done pulse", 32'(done), 32'd1);
    check("busy at done", 32'(busy), 32'd0);
    check("s result", 32'(s), 32'(exp_s));
    check("c result", 32'(c), 32'(exp_c));
    check("v result", 32'(v), 32'(exp_v));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;

    // Reset then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_idle("reset idle");
      check("reset s", 32'(s), 32'd0);
      check("reset c", 32'(c), 32'd0);
      check("reset v", 32'(v), 32'd0);
      @(negedge clk);
    end

    // Directed cases; spec values double-checked against literals.
    run_op(4'b0101, 4'b0011, 1'b0);
    check("add ovf s literal", 32'(s), 32'b1000);
    check("add ovf v literal", 32'(v), 32'd1);
    @(negedge clk); check_idle("after done");
    run_op(4'b0111, 4'b0010, 1'b1);
    check("sub s literal", 32'(s), 32'b0101);
    check("sub c literal", 32'(c), 32'd1);
    @(negedge clk);
    run_op(4'b0011, 4'b0101, 1'b1);
    check("sub borrow s literal", 32'(s), 32'b1110);
    check("sub borrow c literal", 32'(c), 32'd0);
    @(negedge clk);
    run_op(4'b1111, 4'b0001, 1'b0);
    check("wrap s literal", 32'(s), 32'b0000);
    check("wrap c literal", 32'(c), 32'd1);
    @(negedge clk);
    run_op(4'b1000, 4'b0001, 1'b1);
    check("sub ovf s literal", 32'(s), 32'b0111);
    check("sub ovf v literal", 32'(v), 32'd1);
    @(negedge clk);

    // start during SHIFT is ignored; the second pulse targets edge k+2.
    begin
      logic [W-1:0] ms;
      logic mc, mv;
      model(4'b0110, 4'b0111, 1'b0, ms, mc, mv);
      start = 1'b1; a = 4'b0110; b = 4'b0111; sub = 1'b0;
      @(negedge clk);                      // after edge k
      start = 1'b0;
      @(negedge clk);                      // after edge k+1
      start = 1'b1; a = 4'b0001; b = 4'b0001; sub = 1'b1;
      @(negedge clk);                      // after edge k+2
      start = 1'b0;
      check("busy ignores start", 32'(busy), 32'd1);
      @(negedge clk);                      // after edge k+3
      check("busy k+3", 32'(busy), 32'd1);
      @(negedge clk);                      // after edge k+4
      exp_s = ms; exp_c = mc; exp_v = mv;
      check("ignored done", 32'(done), 32'd1);
      check("ignored s first operands", 32'(s), 32'(exp_s));
      check("ignored c", 32'(c), 32'(exp_c));
      check("ignored v", 32'(v), 32'(exp_v));
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check_idle("no second done");
      end
    end

    // start during the DONE cycle is accepted: back-to-back operations.
    run_op(4'b1001, 4'b0100, 1'b1);
    run_op(4'b0100, 4'b0100, 1'b0);
    @(negedge clk);
    check_idle("after back-to-back");

    // Reset mid-operation: rst sampled at edge k+2.
    start = 1'b1; a = 4'b0101; b = 4'b0011; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;
    check_idle("mid reset");
    check("mid reset s", 32'(s), 32'd0);
    check("mid reset c", 32'(c), 32'd0);
    check("mid reset v", 32'(v), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("no done after reset");
    end
    run_op(4'b0101, 4'b0011, 1'b0);
    @(negedge clk);

    // Randomized operations, sometimes chained through the DONE cycle.
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        @(negedge clk);
        check_idle("random idle");
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/serial_add_sub4.md
Name: serial_add_sub4

Overview:
- Bit-serial 4-bit adder/subtractor controller.
- Accepts two operands and a mode bit on a start strobe, then computes A+B or A−B one bit per clock through a single full-adder slice (two half-adder cells plus an OR gate).
- Registers the sum, carry/borrow and signed overflow, and signals completion with a one-cycle done pulse.
- Sits between the switch/button input logic of the adder-subtractor exercise and the result display logic.

Parameters:
- WIDTH, 4, operand and result width in bits; bit counter sized ceil(log2(WIDTH))+1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- sub  input  1  0 = A+B, 1 = A−B; captured on accepted start.
- busy  output  1  high while serial computation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- s  output  WIDTH  registered sum/difference; held until the next completion.
- c  output  1  carry out. For subtraction, 1 = no borrow (A ≥ B unsigned).
- v  output  1  two's-complement overflow.

Behaviour:
- Reset: on rising clk with rst=1, everything clears.
  - State = IDLE.
  - busy, done, s, c, v = 0.
  - Shift registers, carry register and bit counter = 0.
  - rst overrides start and any in-progress operation; a partial result is never output.
- State IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load opA←a, opB←(sub ? ~b : b), carry←sub, counter←0; go to SHIFT.
  - start=0: stay in IDLE.
- State SHIFT: busy=1. Each edge performs one bit step:
  - sum bit = opA[0]^opB[0]^carry;
  - carry ← majority(opA[0], opB[0], carry);
  - shift opA and opB right by one;
  - shift the sum bit into the MSB of the result shift register;
  - counter increments;
  - before the MSB step, the current carry value (carry into MSB) is saved for overflow.
- End of SHIFT, after step WIDTH (counter reaching WIDTH−1 at that edge):
  - s ← completed result register (including the final bit);
  - c ← final carry;
  - v ← carry-into-MSB XOR final carry;
  - go to DONE.
- State DONE: busy=0, done=1 for exactly one cycle.
  - start=1: accept new operands exactly as in IDLE, go to SHIFT.
  - start=0: go to IDLE.
- Latency: start sampled at edge k.
  - busy is high for WIDTH cycles (edge k to edge k+WIDTH).
  - done is high between edges k+WIDTH and k+WIDTH+1.
  - s/c/v change only at edge k+WIDTH.
- start in SHIFT is ignored and not queued. a, b and sub may change freely after capture without affecting the operation.
- s/c/v keep their previous values through IDLE and SHIFT; they update only on completion.
- Throughput: with start held high, one result every WIDTH+1 cycles.
- busy and done are never high together.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, done=0, s=0000, c=0, v=0 indefinitely.
- Add with signed overflow: a=0101, b=0011, sub=0, start 1 cycle -> busy high 4 cycles, then done pulse with s=1000, c=0, v=1.
- Subtract, no borrow: a=0111, b=0010, sub=1 -> s=0101, c=1, v=0. Then a=0011, b=0101, sub=1 -> s=1110, c=0, v=0.
- Wrap and overflow in subtraction: a=1111, b=0001, sub=0 -> s=0000, c=1, v=0. Then a=1000, b=0001, sub=1 -> s=0111, c=1, v=1.
- start ignored while busy: start at k, pulse start again with new a/b at k+2 -> single done at k+4 with the first operands' result. No second done. Start asserted during the DONE cycle is accepted: busy again on the next cycle.
- Reset mid-operation: start at k (5+3), rst=1 at edge k+2 -> busy=0 immediately after that edge, no done pulse, s/c/v=0, and a following start produces a correct result.
